// File: rtl/tick_period_checker_pkg.sv
// -----------------------------------------------------------------------------
// tick_period_checker_pkg
// Shared timing constants for the periodic tick generator/checker pair, plus
// the interval classification type and small helper functions used by the
// checker.
//   TPC_CNT_W          default interval counter / period width
//   TPC_EXP_PERIOD     shared 500 ms period at the system clock rate
//   tpc_win_e          classification of a measured interval
//   tpc_sat_inc8()     8-bit saturating increment
// -----------------------------------------------------------------------------
package tick_period_checker_pkg;

  localparam int unsigned TPC_CNT_W      = 25;
  localparam logic [24:0] TPC_EXP_PERIOD = 25'd25_000_000;
  localparam logic [24:0] TPC_TOL        = 25'd1_000;
  localparam logic [3:0]  TPC_LOCK_CNT   = 4'd3;

  // Where a measured interval P falls relative to the acceptance window.
  typedef enum logic [1:0] {
    TPC_WIN_EARLY = 2'd0,  // P below EXP_PERIOD-TOL
    TPC_WIN_GOOD  = 2'd1,  // inside the window, both ends inclusive
    TPC_WIN_OVER  = 2'd2   // above EXP_PERIOD+TOL (only reachable on a fault)
  } tpc_win_e;

  // Saturating 8-bit increment for event counters.
  function automatic logic [7:0] tpc_sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_interval_cnt.sv
// -----------------------------------------------------------------------------
// tick_interval_cnt
// Counts clock cycles since the last clear. Synchronous clear has priority;
// otherwise increments by one per cycle and holds at all-ones.
// Ports:
//   sys_clk    in   clock
//   sys_rst_n  in   asynchronous active-low reset
//   clr        in   synchronous clear (one accepted tick)
//   cnt        out  CNT_W  current count
// -----------------------------------------------------------------------------
module tick_interval_cnt
  import tick_period_checker_pkg::*;
#(
  parameter int unsigned CNT_W = TPC_CNT_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;

  // Saturating up-counter with synchronous clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r != {CNT_W{1'b1}}) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/tick_period_checker.sv
// -----------------------------------------------------------------------------
// tick_period_checker
// Measures the interval between single-cycle tick_in strobes, checks it
// against EXP_PERIOD +/- TOL, flags early and late ticks, and reports lock
// after LOCK_CNT consecutive in-window intervals. All outputs are registered
// and reflect the tick (or timeout) sampled on the previous edge.
// Ports:
//   sys_clk       in   clock
//   sys_rst_n     in   asynchronous active-low reset
//   tick_in       in   tick strobe, every high cycle is one tick
//   period        out  CNT_W  last measured interval in cycles
//   period_valid  out  pulse, period updated
//   early_err     out  pulse, interval shorter than EXP_PERIOD-TOL
//   late_err      out  pulse, no tick within EXP_PERIOD+TOL
//   locked        out  level, high while locked
//   err_count     out  8  saturating count of early and late errors
// -----------------------------------------------------------------------------
module tick_period_checker
  import tick_period_checker_pkg::*;
#(
  parameter int unsigned      CNT_W      = TPC_CNT_W,
  parameter logic [CNT_W-1:0] EXP_PERIOD = TPC_EXP_PERIOD,
  parameter logic [CNT_W-1:0] TOL        = TPC_TOL,
  parameter logic [3:0]       LOCK_CNT   = TPC_LOCK_CNT
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             early_err,
  output logic             late_err,
  output logic             locked,
  output logic [7:0]       err_count
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Window bounds are one bit wider so EXP_PERIOD+TOL cannot wrap.
  localparam logic [CNT_W:0] WIN_LO_S  = {1'b0, EXP_PERIOD} - {1'b0, TOL};
  localparam logic [CNT_W:0] WIN_HI_S  = {1'b0, EXP_PERIOD} + {1'b0, TOL};
  localparam logic [CNT_W:0] TIMEOUT_S = WIN_HI_S - {{CNT_W{1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W:0]   interval_s;
  tpc_win_e         win_s;
  logic             timeout_s;

  logic [1:0]       state_r;
  logic [1:0]       state_nx_s;
  logic [3:0]       good_cnt_r;
  logic [3:0]       good_cnt_nx_s;
  logic             pv_nx_s;
  logic             early_nx_s;
  logic             late_nx_s;

  logic [CNT_W-1:0] period_r;
  logic             period_valid_r;
  logic             early_err_r;
  logic             late_err_r;
  logic             locked_r;
  logic [7:0]       err_count_r;

  // Every tick restarts the interval, including the reference tick in HUNT.
  tick_interval_cnt #(
    .CNT_W (CNT_W)
  ) u_interval_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (tick_in),
    .cnt       (cnt_s)
  );

  // Interval for a tick this cycle is the sampled count plus one.
  assign interval_s = {1'b0, cnt_s} + {{CNT_W{1'b0}}, 1'b1};
  assign timeout_s  = ({1'b0, cnt_s} == TIMEOUT_S);

  // Classify the candidate interval against the acceptance window.
  always_comb begin
    win_s = TPC_WIN_GOOD;
    if (interval_s < WIN_LO_S) begin
      win_s = TPC_WIN_EARLY;
    end else if (interval_s > WIN_HI_S) begin
      win_s = TPC_WIN_OVER;
    end else begin
      win_s = TPC_WIN_GOOD;
    end
  end

  // Next-state, good-interval run length and event pulses. A tick on the
  // timeout cycle takes priority, so P == EXP_PERIOD+TOL is accepted.
  always_comb begin
    state_nx_s    = state_r;
    good_cnt_nx_s = good_cnt_r;
    pv_nx_s       = 1'b0;
    early_nx_s    = 1'b0;
    late_nx_s     = 1'b0;
    case (state_r)
      ST_HUNT: begin
        if (tick_in) begin
          state_nx_s = ST_TRACK;
        end else begin
          state_nx_s = ST_HUNT;
        end
      end
      ST_TRACK, ST_LOCKED: begin
        if (tick_in) begin
          pv_nx_s = 1'b1;
          case (win_s)
            TPC_WIN_EARLY: begin
              early_nx_s    = 1'b1;
              good_cnt_nx_s = 4'd0;
              state_nx_s    = ST_TRACK;
            end
            TPC_WIN_GOOD: begin
              if (good_cnt_r >= LOCK_CNT) begin
                good_cnt_nx_s = LOCK_CNT;
              end else begin
                good_cnt_nx_s = good_cnt_r + 4'd1;
              end
              if (good_cnt_nx_s == LOCK_CNT) begin
                state_nx_s = ST_LOCKED;
              end else begin
                state_nx_s = ST_TRACK;
              end
            end
            default: begin
              // Interval past the timeout cannot occur; treat as lost timebase.
              late_nx_s     = 1'b1;
              good_cnt_nx_s = 4'd0;
              state_nx_s    = ST_HUNT;
            end
          endcase
        end else if (timeout_s) begin
          late_nx_s     = 1'b1;
          good_cnt_nx_s = 4'd0;
          state_nx_s    = ST_HUNT;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: begin
        good_cnt_nx_s = 4'd0;
        state_nx_s    = ST_HUNT;
      end
    endcase
  end

  // State and run-length registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r    <= ST_HUNT;
      good_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_nx_s;
      good_cnt_r <= good_cnt_nx_s;
    end
  end

  // Registered outputs; locked tracks the next state so it drops on the same
  // edge that raises an error pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      period_r       <= {CNT_W{1'b0}};
      period_valid_r <= 1'b0;
      early_err_r    <= 1'b0;
      late_err_r     <= 1'b0;
      locked_r       <= 1'b0;
      err_count_r    <= 8'd0;
    end else begin
      if (pv_nx_s) begin
        period_r <= interval_s[CNT_W-1:0];
      end else begin
        period_r <= period_r;
      end
      period_valid_r <= pv_nx_s;
      early_err_r    <= early_nx_s;
      late_err_r     <= late_nx_s;
      locked_r       <= (state_nx_s == ST_LOCKED);
      if (early_nx_s || late_nx_s) begin
        err_count_r <= tpc_sat_inc8(err_count_r);
      end else begin
        err_count_r <= err_count_r;
      end
    end
  end

  assign period       = period_r;
  assign period_valid = period_valid_r;
  assign early_err    = early_err_r;
  assign late_err     = late_err_r;
  assign locked       = locked_r;
  assign err_count    = err_count_r;

endmodule

// File: doc/tick_period_checker.md
# tick_period_checker

Receive side of the periodic tick strobe used across the design: consumes a single-cycle `tick_in` pulse, as produced by the team's free-running period counters, and measures the clock-cycle interval between successive pulses. It checks each interval against an expected period ± tolerance, flags early and missing/late ticks, and declares lock after a run of good intervals. It sits at the input of any block that depends on a slow timebase, such as a LED or blink controller or a watchdog, and reports timebase health to status logic.

## Interface
Parameters:
- `CNT_W`, 25: width of interval counter and `period`.
- `EXP_PERIOD`, 25'd25_000_000: expected cycles between ticks.
- `TOL`, 25'd1_000: allowed deviation in cycles. Constraints: `TOL < EXP_PERIOD` and `EXP_PERIOD + TOL < 2**CNT_W`.
- `LOCK_CNT`, 4'd3: consecutive in-window intervals required to lock (≥1).

Ports:
- `sys_clk`  in  1  clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `tick_in`  in  1  synchronous strobe. Each high cycle is one tick.
- `period`  out  CNT_W  last measured interval in cycles.
- `period_valid`  out  1  one-cycle pulse; `period` updated this cycle.
- `early_err`  out  1  one-cycle pulse; measured interval < `EXP_PERIOD-TOL`.
- `late_err`  out  1  one-cycle pulse; no tick within `EXP_PERIOD+TOL`.
- `locked`  out  1  level, high while in LOCKED.
- `err_count`  out  8  saturating count of early and late errors.

## Operation
- Interval counter `cnt`: cleared on every accepted tick, otherwise +1 per cycle, saturating at all-ones. The interval for a tick is P = sampled `cnt` + 1.
- States: HUNT (reset state, no reference tick), TRACK (measuring, not locked), LOCKED.
- HUNT: a tick clears `cnt` and moves to TRACK. No `period_valid` is produced.
- TRACK/LOCKED on a tick:
  - `period` <= P and `period_valid` pulses.
  - If P < `EXP_PERIOD-TOL`: `early_err` pulses, `good_cnt` <= 0, next state TRACK, and `cnt` restarts from this tick.
  - If in window (`EXP_PERIOD-TOL` ≤ P ≤ `EXP_PERIOD+TOL`): `good_cnt` increments, saturating at `LOCK_CNT`. When it reaches `LOCK_CNT`, next state is LOCKED. LOCKED holds on in-window ticks.
- TRACK/LOCKED, no tick, sampled `cnt == EXP_PERIOD+TOL-1`: `late_err` pulses, `good_cnt` <= 0, next state HUNT.
- Simultaneous tick and timeout boundary: the tick wins. P = `EXP_PERIOD+TOL` is in window and no `late_err` is raised.
- `err_count` increments on each `early_err` or `late_err` and saturates at 255. It is cleared only by reset.
- `locked` = (state == LOCKED), registered.
- A `tick_in` held high N cycles counts as N ticks (intervals of 1 → early errors).

## Timing
- All outputs are registered. They update on the edge that samples the tick or timeout, so they are visible the following cycle. Latency is 1 cycle.
- Reset values: `period`=0, `period_valid`=0, `early_err`=0, `late_err`=0, `locked`=0, `err_count`=0, state HUNT, `cnt`=0, `good_cnt`=0.
- Reset mid-operation clears all state immediately (asynchronous). After release the block restarts in HUNT.
- Late detection: with the last tick sampled at edge t0, `late_err` is set at edge t0+`EXP_PERIOD+TOL` if no tick is sampled there.
- `locked` falls at the same edge that raises `early_err` or `late_err`.
- Window comparisons are unsigned and CNT_W+1 bits wide to avoid overflow of `EXP_PERIOD+TOL`.

## Structure
- State encodings (HUNT/TRACK/LOCKED, 2 bits) are local to the module.
- The `CNT_W` default and the shared 500 ms `EXP_PERIOD` constant go in the team's common timing defines include, so generator and checker agree.
- One natural sub-module: `tick_interval_cnt`, a saturating counter with synchronous clear that exposes `cnt`. Window compare, FSM and error counter stay in the top.

## Test plan
Bench parameters: EXP_PERIOD=10, TOL=2, LOCK_CNT=3.
- Ticks every 10 cycles after reset → first tick: no `period_valid`. Each later tick: `period`=10 with `period_valid`. `locked` rises after the 3rd valid interval (4th tick). `err_count`=0.
- Window boundaries from TRACK: intervals 8 and 12 → valid with no error. Interval 7 → `early_err`, `period`=7, `err_count` +1. Interval 13 → `late_err` at edge t0+12, state HUNT, and the following tick yields no `period_valid`.
- Locked, then one interval of 5 → `early_err` and `locked` falls at the same edge. Three further 10-cycle intervals → relock.
- Locked, ticks stop → exactly one `late_err` at edge t0+12, `locked`=0, no further errors while idle. `err_count` +1.
- `tick_in` held high 300 cycles while in TRACK → `err_count` saturates at 255 and does not wrap.
- Assert `sys_rst_n` low mid-interval while locked → all outputs 0 asynchronously. After release, ticks every 10 → relock after 4 ticks.
